// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes, width helpers and port array types for the register file
package regfile_pkg;

    localparam int DW_DEF     = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int NUM_RD_DEF = 2;

    function automatic int aw(int depth);
        return depth > 1 ? $clog2(depth) : 1;
    endfunction

    function automatic int cw(int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic in_range(logic [31:0] a, int depth);
        return a < 32'(depth);
    endfunction

    typedef logic [NUM_RD_DEF-1:0][aw(DEPTH_DEF)-1:0] rd_addr_t;
    typedef logic [NUM_RD_DEF-1:0][DW_DEF-1:0]        rd_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits with issue-over-write priority and a registered popcount
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW = aw(DEPTH),
    localparam int CW = cw(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    output logic [DEPTH-1:0] busy,
    output logic [CW-1:0]    busy_cnt
);

    logic [DEPTH-1:0] busy_nxt;
    logic [CW-1:0]    cnt_nxt;

    // next busy vector: write clears, a same-address issue then sets it again
    always_comb begin
        busy_nxt = busy;
        if (wr_en && in_range(32'(wr_addr), DEPTH)) busy_nxt[wr_addr] = 1'b0;
        if (iss_en && in_range(32'(iss_addr), DEPTH)) busy_nxt[iss_addr] = 1'b1;
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
    end

    // count tracks the next-state vector so it always matches the stored bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// regfile_multiport: multi-read single-write register file with bypass, hazard flags and debug port
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1,
    localparam int AW = aw(DEPTH),
    localparam int CW = cw(DEPTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_RD-1:0][AW-1:0]   rd_addr,
    output logic [NUM_RD-1:0][DW-1:0]   rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DW-1:0]               wr_data,
    input  logic                        iss_en,
    input  logic [AW-1:0]               iss_addr,
    input  logic [AW-1:0]               dbg_sel,
    output logic [DW-1:0]               dbg_data,
    output logic [CW-1:0]               busy_cnt
);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             we;

    assign we = wr_en && in_range(32'(wr_addr), DEPTH) && !(ZERO_REG != 0 && wr_addr == '0);

    regfile_scoreboard #(.DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // storage and debug snapshot; debug sees the pre-write value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            dbg_data <= '0;
        end else begin
            if (we) mem[wr_addr] <= wr_data;
            dbg_data <= in_range(32'(dbg_sel), DEPTH) ? mem[dbg_sel] : '0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic valid, hit;
        assign valid      = in_range(32'(rd_addr[i]), DEPTH) && !(ZERO_REG != 0 && rd_addr[i] == '0);
        assign hit        = wr_en && wr_addr == rd_addr[i];
        assign rd_data[i] = !valid ? '0 : hit ? wr_data : mem[rd_addr[i]];
        assign rd_busy[i] = valid && busy[rd_addr[i]] && !hit;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb_regfile_multiport: directed vectors on the default build, random model check on a 24x16 4-port build
module tb_regfile_multiport;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rd_addr_t    a_ra;
    rd_data_t    a_rd;
    logic [1:0]  a_rb;
    logic        a_we, a_ie;
    logic [4:0]  a_wa, a_ia, a_ds;
    logic [31:0] a_wd, a_dbg;
    logic [5:0]  a_cnt;

    logic [3:0][4:0]  b_ra;
    logic [3:0][15:0] b_rd;
    logic [3:0]       b_rb;
    logic             b_we, b_ie;
    logic [4:0]       b_wa, b_ia, b_ds, b_cnt;
    logic [15:0]      b_wd, b_dbg;

    regfile_multiport dut0 (
        .clk(clk), .reset(reset), .rd_addr(a_ra), .rd_data(a_rd), .rd_busy(a_rb),
        .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .iss_en(a_ie), .iss_addr(a_ia),
        .dbg_sel(a_ds), .dbg_data(a_dbg), .busy_cnt(a_cnt)
    );

    regfile_multiport #(.DW(16), .DEPTH(24), .NUM_RD(4), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .rd_addr(b_ra), .rd_data(b_rd), .rd_busy(b_rb),
        .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .iss_en(b_ie), .iss_addr(b_ia),
        .dbg_sel(b_ds), .dbg_data(b_dbg), .busy_cnt(b_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic we; logic [4:0] wa; logic [31:0] wd; logic ie; logic [4:0] ia;
        logic [4:0] r0, r1, ds;
        logic [31:0] d0; logic b0; logic [31:0] d1; logic b1;
        int cnt; logic [31:0] dbg;
    } vec_t;

    vec_t vt [13];

    logic [15:0] ref_mem [24];
    bit          ref_busy [24];

    function automatic logic [4:0] pick();
        return $urandom_range(0, 9) < 6 ? 5'($urandom_range(0, 7))
             : $urandom_range(0, 3) == 0 ? 5'($urandom_range(24, 31)) : 5'($urandom_range(0, 23));
    endfunction

    initial begin
        logic [15:0] ed, old;
        logic        eb;
        int          pc;
        vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0,  5, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0};
        vt[1]  = '{0, 0, 0,            0, 0,  5, 0, 5, 32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF};
        vt[2]  = '{1, 0, 32'h12345678, 1, 0,  0, 0, 0, 0,            0, 0, 0, 0, 0};
        vt[3]  = '{0, 0, 0,            1, 3,  3, 7, 5, 0,            0, 0, 0, 1, 32'hDEADBEEF};
        vt[4]  = '{0, 0, 0,            1, 7,  3, 7, 5, 0,            1, 0, 0, 2, 32'hDEADBEEF};
        vt[5]  = '{1, 3, 32'h33,       0, 0,  3, 7, 5, 32'h33,       0, 0, 1, 1, 32'hDEADBEEF};
        vt[6]  = '{0, 0, 0,            0, 0,  3, 7, 5, 32'h33,       0, 0, 1, 1, 32'hDEADBEEF};
        vt[7]  = '{0, 0, 0,            1, 9,  9, 7, 5, 0,            0, 0, 1, 2, 32'hDEADBEEF};
        vt[8]  = '{1, 9, 32'h99,       1, 9,  9, 7, 5, 32'h99,       0, 0, 1, 2, 32'hDEADBEEF};
        vt[9]  = '{0, 0, 0,            0, 0,  9, 7, 5, 32'h99,       1, 0, 1, 2, 32'hDEADBEEF};
        vt[10] = '{1, 7, 32'h77,       1, 10, 7, 10, 5, 32'h77,      0, 0, 0, 2, 32'hDEADBEEF};
        vt[11] = '{0, 0, 0,            1, 10, 7, 10, 5, 32'h77,      0, 0, 1, 2, 32'hDEADBEEF};
        vt[12] = '{1, 9, 32'hAA,       0, 0,  9, 10, 9, 32'hAA,      0, 0, 1, 1, 32'h99};

        a_ra = '0; a_we = 0; a_wa = 0; a_wd = 0; a_ie = 0; a_ia = 0; a_ds = 0;
        b_ra = '0; b_we = 0; b_wa = 0; b_wd = 0; b_ie = 0; b_ia = 0; b_ds = 0;
        for (int i = 0; i < 24; i++) begin ref_mem[i] = '0; ref_busy[i] = 0; end

        repeat (2) @(negedge clk);
        a_ra[0] = 5; a_ra[1] = 3;
        #1;
        chk("reset rd0", 64'(a_rd[0]), 0);
        chk("reset cnt", 64'(a_cnt), 0);
        chk("reset dbg", 64'(a_dbg), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            a_we = vt[i].we; a_wa = vt[i].wa; a_wd = vt[i].wd;
            a_ie = vt[i].ie; a_ia = vt[i].ia;
            a_ra[0] = vt[i].r0; a_ra[1] = vt[i].r1; a_ds = vt[i].ds;
            #1;
            chk($sformatf("v%0d rd0", i), 64'(a_rd[0]), 64'(vt[i].d0));
            chk($sformatf("v%0d busy0", i), 64'(a_rb[0]), 64'(vt[i].b0));
            chk($sformatf("v%0d rd1", i), 64'(a_rd[1]), 64'(vt[i].d1));
            chk($sformatf("v%0d busy1", i), 64'(a_rb[1]), 64'(vt[i].b1));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cnt", i), 64'(a_cnt), 64'(vt[i].cnt));
            chk($sformatf("v%0d dbg", i), 64'(a_dbg), 64'(vt[i].dbg));
        end

        @(negedge clk);
        a_we = 0; a_ie = 0; a_ra[0] = 5; a_ra[1] = 10; a_ds = 5;
        #1;
        chk("pre-reset busy r10", 64'(a_rb[1]), 1);
        chk("pre-reset rd r5", 64'(a_rd[0]), 64'h0DEADBEEF);
        reset = 1'b0;
        #1;
        chk("async reset rd r5", 64'(a_rd[0]), 0);
        chk("async reset busy r10", 64'(a_rb[1]), 0);
        chk("async reset cnt", 64'(a_cnt), 0);
        chk("async reset dbg", 64'(a_dbg), 0);
        a_we = 1; a_wa = 5; a_wd = 32'h1234; a_ie = 1; a_ia = 3;
        @(posedge clk);
        #1;
        a_we = 0; a_ie = 0; a_ra[1] = 3;
        #1;
        chk("reset-held write", 64'(a_rd[0]), 0);
        chk("reset-held issue", 64'(a_rb[1]), 0);
        chk("reset-held cnt", 64'(a_cnt), 0);
        @(negedge clk);
        reset = 1'b1;

        @(negedge clk);
        b_we = 1; b_wa = 30; b_wd = 16'hBEEF; b_ie = 1; b_ia = 30;
        for (int p = 0; p < 4; p++) b_ra[p] = 30;
        #1;
        chk("addr30 bypass rd", 64'(b_rd[0]), 0);
        chk("addr30 bypass busy", 64'(b_rb[0]), 0);
        @(posedge clk);
        #1;
        b_we = 0; b_ie = 0;
        #1;
        chk("addr30 cnt", 64'(b_cnt), 0);
        for (int p = 0; p < 4; p++) chk($sformatf("addr30 rd%0d", p), 64'(b_rd[p]), 0);

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            b_we = 1'($urandom_range(0, 1)); b_wa = pick(); b_wd = 16'($urandom);
            b_ie = 1'($urandom_range(0, 1)); b_ia = pick();
            for (int p = 0; p < 4; p++) b_ra[p] = pick();
            b_ds = 5'($urandom_range(0, 23));
            #1;
            for (int p = 0; p < 4; p++) begin
                if (b_ra[p] == 0 || b_ra[p] >= 24) begin ed = 0; eb = 0; end
                else if (b_we && b_wa == b_ra[p]) begin ed = b_wd; eb = 0; end
                else begin ed = ref_mem[b_ra[p]]; eb = ref_busy[b_ra[p]]; end
                chk($sformatf("rnd%0d rd%0d a=%0d", c, p, b_ra[p]), 64'(b_rd[p]), 64'(ed));
                chk($sformatf("rnd%0d busy%0d a=%0d", c, p, b_ra[p]), 64'(b_rb[p]), 64'(eb));
            end
            old = ref_mem[b_ds];
            if (b_we && b_wa != 0 && b_wa < 24) begin ref_mem[b_wa] = b_wd; ref_busy[b_wa] = 0; end
            if (b_ie && b_ia != 0 && b_ia < 24) ref_busy[b_ia] = 1;
            pc = 0;
            for (int r = 0; r < 24; r++) pc += int'(ref_busy[r]);
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d cnt", c), 64'(b_cnt), 64'(pc));
            chk($sformatf("rnd%0d dbg sel=%0d", c, b_ds), 64'(b_dbg), 64'(old));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register file for the CPU datapath: a configurable number of combinational read ports and one write port with same-cycle write-to-read bypass, plus an optional hardwired zero register. It adds a pending-write scoreboard for pipeline hazard detection and a registered debug read port that drives the board GPIO display. It sits between decode (read, issue) and writeback (write).

## Interface
- DW, 32, data width in bits
- DEPTH, 32, number of registers; AW = $clog2(DEPTH)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 always reads 0 and ignores writes and issues
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- rd_addr  in  NUM_RD×AW  read addresses
- rd_data  out  NUM_RD×DW  read data, combinational
- rd_busy  out  NUM_RD  pending-write flag per read port, combinational
- wr_en  in  1  write enable, active-high
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- iss_en  in  1  issue: mark iss_addr as pending writeback
- iss_addr  in  AW  destination register of the issued instruction
- dbg_sel  in  AW  debug register select (board switches)
- dbg_data  out  DW  registered contents of register dbg_sel (to GPIO)
- busy_cnt  out  $clog2(DEPTH+1)  registered count of pending registers

## Operation
- Storage: DEPTH×DW flops. A write occurs at the rising edge when wr_en=1. If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read port i: rd_data[i] = 0 if ZERO_REG and rd_addr[i]=0. Otherwise it is wr_data if wr_en and wr_addr=rd_addr[i] (bypass). Otherwise it is the stored value.
- Scoreboard: busy vector of DEPTH bits.
  - iss_en sets busy[iss_addr].
  - wr_en clears busy[wr_addr].
  - iss_en and wr_en to the same address in the same cycle leaves the bit set (the new issue wins).
  - With ZERO_REG=1, issues and writes to address 0 never set it.
- rd_busy[i] = busy[rd_addr[i]] AND NOT(wr_en AND wr_addr=rd_addr[i]). The bypass resolves the hazard in the same cycle. With ZERO_REG=1, rd_busy is always 0 for address 0.
- busy_cnt: popcount of the next-state busy vector, registered. It therefore always equals the popcount of the current busy vector.
- Debug port: dbg_data <= stored[dbg_sel] each cycle. There is no bypass: dbg_data shows the pre-write value during a write cycle.
- Addresses ≥ DEPTH (non-power-of-two DEPTH): writes and issues are ignored; reads return 0 and rd_busy=0.

## Timing
- Reset assertion clears registers, busy, dbg_data and busy_cnt to 0 asynchronously. This holds mid-operation: pending state is lost, and no write completes on the edge where reset is low.
- First write is accepted on the first rising edge after reset deasserts.
- Read latency: 0 cycles, bypass included.
- A write at edge n is visible on the read ports from edge n onward and on dbg_data from edge n+1.
- Scoreboard:
  - iss_en at edge n makes rd_busy high after edge n and busy_cnt increment after edge n.
  - wr_en at edge m clears rd_busy combinationally during cycle m and in storage after edge m.
- Issue and write to different addresses in the same cycle: busy_cnt is unchanged.
- Duplicate issue to an already-busy register: no change to busy_cnt.

## Structure
- Package regfile_pkg holds the DW/DEPTH defaults, the AW/CW width functions and the typedef for the read-address/data port arrays.
- Sub-module regfile_scoreboard holds the busy vector, its set/clear priority and busy_cnt. The top holds storage, read muxes and the debug port.

## Test plan
- Reset: drive reset=0 mid-run with nonzero registers and busy bits. All reads return 0, busy_cnt=0 and dbg_data=0 immediately, with no clock edge.
- Write/read: write 0xDEADBEEF to r5. In the same cycle, rd_addr[0]=5 returns 0xDEADBEEF (bypass); the next cycle it still returns it. dbg_sel=5 gives 0xDEADBEEF one cycle later.
- Zero register: write 0x12345678 to r0 and issue r0. Reads return 0, rd_busy=0 and busy_cnt=0.
- Scoreboard: issue r3 then r7. busy_cnt goes 1 then 2, and rd_busy for r3 is 1. Write r3: rd_busy drops in the same cycle, and busy_cnt=1 after the edge.
- Collision: issue r9 and write r9 in the same cycle. r9 stays busy and busy_cnt is unchanged. The read returns the new wr_data.
- Parameter sweep: DEPTH=24, NUM_RD=4, DW=16. Random issue/write/read is checked against a reference model. Address 30 reads 0 and writes to it are dropped.
